// File: rtl/tmr_pkg.sv
// Shared types and constants for the triple-redundant scrub controller.
package tmr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      FIX
   } state_e;

   localparam int COPY_A = 0;
   localparam int COPY_B = 1;
   localparam int COPY_C = 2;

   localparam logic [1:0] INJ_SEL_NONE = 2'd3;

   // popcount(syn) >= 2 is the majority of the three syndrome bits
   function automatic logic multi_hit(input logic [2:0] syn);
      return (syn[0] & syn[1]) | (syn[1] & syn[2]) | (syn[0] & syn[2]);
   endfunction

endpackage

// File: rtl/tmr_maj3.sv
// Bitwise 2-of-3 majority voter.
module tmr_maj3
   import tmr_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] y
);

   assign y = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/tmr_scrub.sv
// Triple-redundant register bank with background scrub and upset counter.
// Optional TMR_SCRUB_LOG_EN adds LOG_ADDR/LOG_SYN of the last correction.
module tmr_scrub
   import tmr_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 8,
   parameter int SCRUB_DIV = 1024,
   parameter int ECNT_W    = 16,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              WE,
   input  logic              INJ_WE,
   input  logic [1:0]        INJ_SEL,
   input  logic [AW-1:0]     WADDR,
   input  logic [WIDTH-1:0]  WDATA,
   input  logic [AW-1:0]     RADDR,
   output logic [WIDTH-1:0]  RDATA,
   input  logic              SCRUB_EN,
   input  logic              ERR_CLR,
   output logic [ECNT_W-1:0] ERR_CNT,
   output logic              ERR_PULSE,
   output logic              MULTI,
   output logic              BUSY
`ifdef TMR_SCRUB_LOG_EN
   ,
   output logic [AW-1:0]     LOG_ADDR,
   output logic [2:0]        LOG_SYN
`endif
);

   localparam int DW = $clog2(SCRUB_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCRUB_DIV - 1);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [WIDTH-1:0]  cp_q [3][DEPTH];
   state_e            state_q, state_d;
   logic [DW-1:0]     div_q, div_d;
   logic [AW-1:0]     ptr_q, ptr_d;
   logic [WIDTH-1:0]  vote_c, vote_q;
   logic [2:0]        syn_c, syn_q;
   logic              conf_q;
   logic              host_hit;
   logic              corr;
   logic              inj_ok;
   logic [ECNT_W-1:0] cnt_q;
   logic              pulse_q, multi_q;

   tmr_maj3 #(.WIDTH(WIDTH)) u_rd_vote (
      .a (cp_q[COPY_A][RADDR]),
      .b (cp_q[COPY_B][RADDR]),
      .c (cp_q[COPY_C][RADDR]),
      .y (RDATA)
   );

   tmr_maj3 #(.WIDTH(WIDTH)) u_scrub_vote (
      .a (cp_q[COPY_A][ptr_q]),
      .b (cp_q[COPY_B][ptr_q]),
      .c (cp_q[COPY_C][ptr_q]),
      .y (vote_c)
   );

   always_comb begin
      syn_c[COPY_A] = cp_q[COPY_A][ptr_q] != vote_c;
      syn_c[COPY_B] = cp_q[COPY_B][ptr_q] != vote_c;
      syn_c[COPY_C] = cp_q[COPY_C][ptr_q] != vote_c;
   end

   assign host_hit = WE && (WADDR == ptr_q);
   assign inj_ok   = INJ_WE && (INJ_SEL != INJ_SEL_NONE);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      ptr_d   = ptr_q;
      corr    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!SCRUB_EN) begin
               div_d = '0;
            end else if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = READ;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         READ: state_d = FIX;
         FIX: begin
            // a host write seen in READ or FIX owns the word
            corr    = (|syn_q) && !(conf_q || host_hit);
            ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         div_q   <= '0;
         ptr_q   <= '0;
         vote_q  <= '0;
         syn_q   <= '0;
         conf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         ptr_q   <= ptr_d;
         if (state_q == READ) begin
            vote_q <= vote_c;
            syn_q  <= syn_c;
            conf_q <= host_hit;
         end
      end
   end

   // priority per copy: host write, scrub write-back, injection
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int k = 0; k < 3; k++)
            for (int a = 0; a < DEPTH; a++)
               cp_q[k][a] <= '0;
      end else begin
         for (int k = 0; k < 3; k++)
            for (int a = 0; a < DEPTH; a++)
               if (WE && WADDR == AW'(a))
                  cp_q[k][a] <= WDATA;
               else if (corr && ptr_q == AW'(a))
                  cp_q[k][a] <= vote_q;
               else if (inj_ok && INJ_SEL == 2'(k)
                        && WADDR == AW'(a))
                  cp_q[k][a] <= WDATA;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         if (ERR_CLR)
            cnt_q <= '0;
         else if (corr && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
         pulse_q <= corr;
         multi_q <= corr && multi_hit(syn_q);
      end
   end

`ifdef TMR_SCRUB_LOG_EN
   logic [AW-1:0] log_addr_q;
   logic [2:0]    log_syn_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         log_addr_q <= '0;
         log_syn_q  <= '0;
      end else if (ERR_CLR) begin
         log_addr_q <= '0;
         log_syn_q  <= '0;
      end else if (corr) begin
         log_addr_q <= ptr_q;
         log_syn_q  <= syn_q;
      end
   end

   assign LOG_ADDR = log_addr_q;
   assign LOG_SYN  = log_syn_q;
`endif

   assign ERR_CNT   = cnt_q;
   assign ERR_PULSE = pulse_q;
   assign MULTI     = multi_q;
   assign BUSY      = state_q != IDLE;

endmodule
